// File: rtl/pid_loop_sched.sv
// pid_loop_sched: tick-driven cascaded PD sequencer sharing one 16x16 signed multiplier.
// Ports: clk, rst_n (async, active-low), en (tick enable), kp/kd/zhongzhi (angle loop),
// posi_kp/posi_kd/positon_target/posi_Sensor (position loop), Sensor (angle),
// Motor (saturated command), motor_valid (update pulse), busy (FSM not idle), sat (last update clipped).
// Macro CASCADE_POS_EN enables the outer position loop; undefined gives an angle-only controller.
module pid_loop_sched #(
  parameter int DIV       = 1000,
  parameter int POS_RATIO = 5,
  parameter int SHIFT     = 0,
  parameter int MOTOR_MAX = 7200
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic signed [15:0] kp,
  input  logic signed [15:0] kd,
  input  logic signed [15:0] zhongzhi,
  input  logic signed [15:0] posi_kp,
  input  logic signed [15:0] posi_kd,
  input  logic signed [15:0] positon_target,
  input  logic signed [15:0] posi_Sensor,
  input  logic signed [15:0] Sensor,
  output logic signed [15:0] Motor,
  output logic               motor_valid,
  output logic               busy,
  output logic               sat
);
  localparam logic [2:0] S_IDLE = 3'd0, S_LATCH = 3'd1, S_PP = 3'd2, S_PD = 3'd3,
                         S_AP = 3'd4, S_AD = 3'd5, S_OUT = 3'd6;
  localparam int CW = $clog2(DIV);
  localparam logic signed [33:0] L_MAX = 34'(MOTOR_MAX);
  localparam logic signed [33:0] L_MIN = -L_MAX;
  function automatic logic signed [15:0] sat16(input logic signed [33:0] x);
    return x > 34'sd32767 ? 16'h7fff : x < -34'sd32768 ? 16'h8000 : x[15:0];
  endfunction
  logic [2:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic signed [15:0] r_kp, r_kd, r_zz, r_sens, r_ang_err, r_ang_prev;
  logic signed [33:0] r_acc;
  logic               w_tick;
  logic signed [15:0] w_ang_err, w_ang_derr, w_ma, w_mb;
  logic signed [31:0] w_prod;
  logic signed [33:0] w_sum, w_out;
  assign busy       = r_state != S_IDLE;
  assign w_tick     = en && r_cnt == CW'(DIV - 1);
  assign w_ang_derr = sat16(34'(r_ang_err) - 34'(r_ang_prev));
  assign w_prod     = w_ma * w_mb;
  assign w_sum      = r_acc + 34'(w_prod);
  assign w_out      = r_acc >>> SHIFT;
`ifdef CASCADE_POS_EN
  localparam int PW = $clog2(POS_RATIO + 1);
  logic [PW-1:0]      r_pcnt;
  logic signed [15:0] r_pkp, r_pkd, r_pos_err, r_pos_derr, r_pos_prev, r_pos_out;
  logic signed [33:0] w_shr;
  assign w_shr     = w_sum >>> SHIFT;
  // 18-bit wide intermediate is covered by the 34-bit sat16 input
  assign w_ang_err = sat16(34'(r_zz) + 34'(r_pos_out) - 34'(r_sens));
  assign w_ma = r_state == S_PP ? r_pkp : r_state == S_PD ? r_pkd : r_state == S_AP ? r_kp : r_kd;
  assign w_mb = r_state == S_PP ? r_pos_err : r_state == S_PD ? r_pos_derr :
                r_state == S_AP ? w_ang_err : w_ang_derr;
`else
  logic w_unused;
  assign w_unused  = ^{posi_kp, posi_kd, positon_target, posi_Sensor, 1'(POS_RATIO)};
  assign w_ang_err = sat16(34'(r_zz) - 34'(r_sens));
  assign w_ma = r_state == S_AP ? r_kp : r_kd;
  assign w_mb = r_state == S_AP ? w_ang_err : w_ang_derr;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_kp        <= '0;
      r_kd        <= '0;
      r_zz        <= '0;
      r_sens      <= '0;
      r_ang_err   <= '0;
      r_ang_prev  <= '0;
      r_acc       <= '0;
      Motor       <= '0;
      motor_valid <= 1'b0;
      sat         <= 1'b0;
`ifdef CASCADE_POS_EN
      r_pcnt      <= '0;
      r_pkp       <= '0;
      r_pkd       <= '0;
      r_pos_err   <= '0;
      r_pos_derr  <= '0;
      r_pos_prev  <= '0;
      r_pos_out   <= '0;
`endif
    end else begin
      r_cnt       <= !en || r_cnt == CW'(DIV - 1) ? '0 : r_cnt + CW'(1);
      motor_valid <= 1'b0;
      case (r_state)
        S_IDLE: r_state <= w_tick ? S_LATCH : S_IDLE;
        S_LATCH: begin
          r_kp   <= kp;
          r_kd   <= kd;
          r_zz   <= zhongzhi;
          r_sens <= Sensor;
`ifdef CASCADE_POS_EN
          r_pkp     <= posi_kp;
          r_pkd     <= posi_kd;
          r_pos_err <= sat16(34'(positon_target) - 34'(posi_Sensor));
          // divider advances only on accepted ticks, so a dropped tick never skews it
          r_pcnt    <= r_pcnt == PW'(POS_RATIO - 1) ? '0 : r_pcnt + PW'(1);
          r_state   <= r_pcnt == '0 ? S_PP : S_AP;
`else
          r_state <= S_AP;
`endif
        end
`ifdef CASCADE_POS_EN
        S_PP: begin
          r_acc      <= 34'(w_prod);
          r_pos_derr <= sat16(34'(r_pos_err) - 34'(r_pos_prev));
          r_state    <= S_PD;
        end
        S_PD: begin
          r_acc      <= w_sum;
          r_pos_out  <= sat16(w_shr);
          r_pos_prev <= r_pos_err;
          r_state    <= S_AP;
        end
`endif
        S_AP: begin
          r_acc     <= 34'(w_prod);
          r_ang_err <= w_ang_err;
          r_state   <= S_AD;
        end
        S_AD: begin
          r_acc      <= w_sum;
          r_ang_prev <= r_ang_err;
          r_state    <= S_OUT;
        end
        S_OUT: begin
          Motor       <= w_out > L_MAX ? L_MAX[15:0] : w_out < L_MIN ? L_MIN[15:0] : w_out[15:0];
          sat         <= w_out > L_MAX || w_out < L_MIN;
          motor_valid <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_pid_loop_sched.sv
// tb_pid_loop_sched: scoreboard bench for pid_loop_sched, expectations for both CASCADE_POS_EN builds.
`timescale 1ns/1ps
module tb_pid_loop_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic signed [15:0] kp, kd, zhongzhi, posi_kp, posi_kd, positon_target, posi_Sensor, Sensor, Motor;
  logic motor_valid, busy, sat;
  typedef struct {int motor; int sat; int lat;} exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0, cyc = 0, t_start = 0;
  logic prev_busy = 1'b0;
`ifdef CASCADE_POS_EN
  localparam int LAT_P = 7, M_NOM = 2600, M_ANG = 1100, M_R3 = 1200, KP_SAT = 10, M_LAST = -700;
`else
  localparam int LAT_P = 5, M_NOM = 600, M_ANG = 100, M_R3 = 200, KP_SAT = 30, M_LAST = 6300;
`endif
  pid_loop_sched #(.DIV(10), .POS_RATIO(5), .SHIFT(0), .MOTOR_MAX(7200)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .kp(kp), .kd(kd), .zhongzhi(zhongzhi),
    .posi_kp(posi_kp), .posi_kd(posi_kd), .positon_target(positon_target),
    .posi_Sensor(posi_Sensor), .Sensor(Sensor), .Motor(Motor),
    .motor_valid(motor_valid), .busy(busy), .sat(sat)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask
  task automatic expect_run(input int m, input int s, input int l);
    exp_t t;
    t.motor = m;
    t.sat = s;
    t.lat = l;
    q.push_back(t);
  endtask
  task automatic set_nom();
    kp = 1; kd = 1; zhongzhi = 1000; posi_kp = 1; posi_kd = 1;
    positon_target = 2000; posi_Sensor = 1500; Sensor = 700;
  endtask
  task automatic wait_valid(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (!motor_valid && n < 60);
    if (!motor_valid) begin
      checks++; errors++;
      $display("FAIL %s_timeout: motor_valid not seen within %0d cycles", nm, n);
    end
    @(negedge clk);
  endtask
  task automatic wait_busy(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (!busy && n < 40);
    if (!busy) begin
      checks++; errors++;
      $display("FAIL %s_busy_timeout: busy not seen within %0d cycles", nm, n);
    end
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_motor"}, int'(Motor), 0);
    chk({nm, "_valid"}, int'(motor_valid), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_sat"}, int'(sat), 0);
  endtask
  // monitor: latency is counted from the LATCH cycle (busy rising, tick+1) to the valid cycle
  always @(negedge clk) begin
    if (busy && !prev_busy) t_start = cyc;
    prev_busy = busy;
    if (motor_valid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid: got Motor=%0d with nothing expected", Motor);
      end else begin
        e = q.pop_front();
        chk("motor", int'(Motor), e.motor);
        chk("sat", int'(sat), e.sat);
        chk("latency", cyc - t_start + 1, e.lat);
      end
    end
  end
  initial begin
    set_nom();
    en = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    expect_run(M_NOM, 0, LAT_P);
    wait_valid("nominal");
    Sensor = 800;
    posi_Sensor = 1700;
    expect_run(M_ANG, 0, 5);
    wait_valid("angle_only");
    expect_run(M_R3, 0, 5);
    wait_busy("en_drop");
    @(negedge clk);
    Sensor = 5000;
    en = 1'b0;
    wait_valid("en_drop");
    repeat (40) @(negedge clk);
    chk("hold_motor", int'(Motor), M_R3);
    chk("hold_busy", int'(busy), 0);
    set_nom();
    en = 1'b1;
    wait_busy("mid_reset");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    expect_run(M_NOM, 0, LAT_P);
    wait_valid("after_reset");
    rst_n = 1'b0;
    kp = 16'(KP_SAT);
    @(negedge clk);
    rst_n = 1'b1;
    expect_run(7200, 1, LAT_P);
    wait_valid("sat_pos");
    rst_n = 1'b0;
    zhongzhi = -1000;
    positon_target = -2000;
    @(negedge clk);
    rst_n = 1'b1;
    expect_run(-7200, 1, LAT_P);
    wait_valid("sat_neg");
    kp = 1;
    kd = 0;
    zhongzhi = 7000;
    expect_run(M_LAST, 0, 5);
    wait_valid("sat_clear");
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
